// File: rtl/triangle_pwm_core.sv
// Burst PWM engine: fixed-period PWM whose duty ramps up and down in a triangle,
// one step per PWM period, while the control FSM holds active high.
module triangle_pwm_core #(
  parameter int unsigned PWM_RESOLUTION = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      active,
  input  logic [PWM_RESOLUTION-1:0] pwm_top,
  input  logic [PWM_RESOLUTION-1:0] step,
  input  logic [PWM_RESOLUTION-1:0] peak,
  output logic                      pwm_out,
  output logic [PWM_RESOLUTION-1:0] duty,
  output logic                      dir,
  output logic                      period_tick,
  output logic [PWM_RESOLUTION-1:0] period_counter
);

  localparam int unsigned W = PWM_RESOLUTION;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic         dir_q, dir_d;
  logic         pwm_q, pwm_d;
  logic [W-1:0] pcnt_q, pcnt_d;
  logic [W-1:0] top_s_q, top_s_d;
  logic [W-1:0] step_s_q, step_s_d;
  logic [W-1:0] peak_s_q, peak_s_d;

  logic         wrap;
  logic [W:0]   duty_up;
  logic [W-1:0] duty_ramp;
  logic         dir_ramp;

  assign wrap = (state_q == RUN) && (cnt_q == top_s_q);

  // Triangle step evaluated one bit wider so apex/floor clamp without wrap-around.
  always_comb begin
    duty_up   = {1'b0, duty_q} + {1'b0, step_s_q};
    duty_ramp = duty_q;
    dir_ramp  = dir_q;
    if (!dir_q) begin
      if (duty_up >= {1'b0, peak_s_q}) begin
        duty_ramp = peak_s_q;
        dir_ramp  = 1'b1;
      end else begin
        duty_ramp = duty_up[W-1:0];
      end
    end else begin
      if (duty_q <= step_s_q) begin
        duty_ramp = '0;
        dir_ramp  = 1'b0;
      end else begin
        duty_ramp = duty_q - step_s_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    pwm_d    = 1'b0;
    pcnt_d   = pcnt_q;
    top_s_d  = top_s_q;
    step_s_d = step_s_q;
    peak_s_d = peak_s_q;

    case (state_q)
      IDLE: begin
        if (active) begin
          state_d  = RUN;
          cnt_d    = '0;
          duty_d   = '0;
          dir_d    = 1'b0;
          pcnt_d   = '0;
          top_s_d  = pwm_top;
          step_s_d = step;
          peak_s_d = peak;
        end
      end
      RUN: begin
        // Dropping active aborts immediately, overriding any wrap on the same edge.
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
          duty_d  = '0;
          dir_d   = 1'b0;
          pcnt_d  = '0;
        end else begin
          pwm_d = (cnt_q < duty_q);
          if (wrap) begin
            cnt_d  = '0;
            duty_d = duty_ramp;
            dir_d  = dir_ramp;
            if (pcnt_q != '1) begin
              pcnt_d = pcnt_q + ONE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      pwm_q    <= 1'b0;
      pcnt_q   <= '0;
      top_s_q  <= '0;
      step_s_q <= '0;
      peak_s_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      pwm_q    <= pwm_d;
      pcnt_q   <= pcnt_d;
      top_s_q  <= top_s_d;
      step_s_q <= step_s_d;
      peak_s_q <= peak_s_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign duty           = duty_q;
  assign dir            = dir_q;
  assign period_tick    = wrap;
  assign period_counter = pcnt_q;

endmodule

// File: tb/tb_triangle_pwm_core.sv
// Directed bench for triangle_pwm_core: outputs sampled on the falling edge.
module tb_triangle_pwm_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        active;
  logic [15:0] pwm_top, step, peak;
  logic        pwm_out, dir, period_tick;
  logic [15:0] duty, period_counter;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  triangle_pwm_core #(.PWM_RESOLUTION(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .active         (active),
    .pwm_top        (pwm_top),
    .step           (step),
    .peak           (peak),
    .pwm_out        (pwm_out),
    .duty           (duty),
    .dir            (dir),
    .period_tick    (period_tick),
    .period_counter (period_counter)
  );

  task automatic start_burst(input logic [15:0] top, input logic [15:0] st, input logic [15:0] pk);
    @(negedge clk);
    pwm_top = top;
    step    = st;
    peak    = pk;
    active  = 1'b1;
  endtask

  task automatic end_burst;
    @(negedge clk);
    active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; active = 1'b0; pwm_top = 16'd3; step = 16'd1; peak = 16'd2;
    #3;
    n_checks++;
    if ({pwm_out, dir, period_tick, duty, period_counter} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0h required 0", {pwm_out, dir, period_tick, duty, period_counter});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({pwm_out, dir, period_tick, duty, period_counter} !== 35'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %0h required 0", {pwm_out, dir, period_tick, duty, period_counter});
    end
  endtask

  task automatic test_triangle;
    int ed [6] = '{0, 1, 2, 1, 0, 1};
    int ex [6] = '{0, 0, 1, 1, 0, 0};
    logic exp_pwm;
    start_burst(16'd3, 16'd1, 16'd2);
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (p == 0 && c == 0) begin
          pwm_top = 16'd7; step = 16'd9; peak = 16'd20;
        end
        if (c == 0) exp_pwm = (p == 0) ? 1'b0 : (3 < ed[p-1]);
        else        exp_pwm = ((c - 1) < ed[p]);
        n_checks++;
        if (duty !== 16'(ed[p])) begin
          n_fail++; $display("FAIL t1_duty p=%0d c=%0d: got %0d required %0d", p, c, duty, ed[p]);
        end
        n_checks++;
        if (dir !== ex[p][0]) begin
          n_fail++; $display("FAIL t1_dir p=%0d c=%0d: got %0b required %0b", p, c, dir, ex[p][0]);
        end
        n_checks++;
        if (period_tick !== (c == 3)) begin
          n_fail++; $display("FAIL t1_tick p=%0d c=%0d: got %0b required %0b", p, c, period_tick, (c == 3));
        end
        n_checks++;
        if (period_counter !== 16'(p)) begin
          n_fail++; $display("FAIL t1_pcnt p=%0d c=%0d: got %0d required %0d", p, c, period_counter, p);
        end
        n_checks++;
        if (pwm_out !== exp_pwm) begin
          n_fail++; $display("FAIL t1_pwm p=%0d c=%0d: got %0b required %0b", p, c, pwm_out, exp_pwm);
        end
      end
    end
    end_burst();
  endtask

  task automatic test_pwm_pattern;
    logic [3:0] pat = 4'b0011;
    start_burst(16'd3, 16'd2, 16'd2);
    repeat (5) @(negedge clk);
    n_checks++;
    if (duty !== 16'd2) begin
      n_fail++; $display("FAIL t2_duty: got %0d required 2", duty);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== pat[i]) begin
        n_fail++; $display("FAIL t2_pwm i=%0d: got %0b required %0b", i, pwm_out, pat[i]);
      end
    end
    end_burst();
  endtask

  task automatic test_duty_extremes;
    start_burst(16'd3, 16'd5, 16'd7);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== (k >= 5)) begin
        n_fail++; $display("FAIL ext_pwm k=%0d: got %0b required %0b", k, pwm_out, (k >= 5));
      end
    end
    end_burst();
  endtask

  task automatic test_ramp_clamp;
    int ed [6] = '{0, 5, 7, 2, 0, 5};
    int ex [6] = '{0, 0, 1, 1, 0, 0};
    start_burst(16'd15, 16'd5, 16'd7);
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      n_checks++;
      if (duty !== 16'(ed[p]) || dir !== ex[p][0]) begin
        n_fail++;
        $display("FAIL t3_ramp p=%0d: got duty %0d dir %0b required duty %0d dir %0b", p, duty, dir, ed[p], ex[p][0]);
      end
      repeat (15) @(negedge clk);
      n_checks++;
      if (period_tick !== 1'b1) begin
        n_fail++; $display("FAIL t3_tick p=%0d: got %0b required 1", p, period_tick);
      end
    end
    end_burst();
  endtask

  task automatic test_abort_restart;
    start_burst(16'd3, 16'd1, 16'd2);
    repeat (14) @(negedge clk);
    n_checks++;
    if ({pwm_out, dir, duty, period_counter} !== {1'b1, 1'b1, 16'd1, 16'd3}) begin
      n_fail++;
      $display("FAIL t4_pre_drop: got pwm %0b dir %0b duty %0d pcnt %0d required 1 1 1 3", pwm_out, dir, duty, period_counter);
    end
    active = 1'b0; pwm_top = 16'd1;
    @(negedge clk);
    n_checks++;
    if ({pwm_out, dir, period_tick, duty, period_counter} !== 35'd0) begin
      n_fail++; $display("FAIL t4_dropped: got %0h required 0", {pwm_out, dir, period_tick, duty, period_counter});
    end
    active = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({period_tick, duty, period_counter} !== 33'd0) begin
      n_fail++; $display("FAIL t4_restart: got %0h required 0", {period_tick, duty, period_counter});
    end
    @(negedge clk);
    n_checks++;
    if (period_tick !== 1'b1) begin
      n_fail++; $display("FAIL t4_new_top_tick: got %0b required 1", period_tick);
    end
    @(negedge clk);
    n_checks++;
    if (period_counter !== 16'd1 || duty !== 16'd1 || period_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_new_top_wrap: got pcnt %0d duty %0d tick %0b required 1 1 0", period_counter, duty, period_tick);
    end
    end_burst();
  endtask

  task automatic test_drop_at_wrap;
    start_burst(16'd3, 16'd1, 16'd2);
    repeat (4) @(negedge clk);
    n_checks++;
    if (period_tick !== 1'b1) begin
      n_fail++; $display("FAIL wrapdrop_tick: got %0b required 1", period_tick);
    end
    active = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pwm_out, dir, period_tick, duty, period_counter} !== 35'd0) begin
      n_fail++; $display("FAIL wrapdrop_idle: got %0h required 0", {pwm_out, dir, period_tick, duty, period_counter});
    end
  endtask

  task automatic test_async_reset;
    start_burst(16'd3, 16'd1, 16'd2);
    repeat (10) @(negedge clk);
    n_checks++;
    if (pwm_out !== 1'b1 || duty !== 16'd2 || period_counter !== 16'd2) begin
      n_fail++;
      $display("FAIL t5_pre_reset: got pwm %0b duty %0d pcnt %0d required 1 2 2", pwm_out, duty, period_counter);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pwm_out, dir, period_tick, duty, period_counter} !== 35'd0) begin
      n_fail++; $display("FAIL t5_async: got %0h required 0", {pwm_out, dir, period_tick, duty, period_counter});
    end
    pwm_top = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (period_tick !== 1'b1 || period_counter !== 16'd0 || duty !== 16'd0) begin
      n_fail++;
      $display("FAIL t5_first_run: got tick %0b pcnt %0d duty %0d required 1 0 0", period_tick, period_counter, duty);
    end
    @(negedge clk);
    n_checks++;
    if (period_counter !== 16'd1 || duty !== 16'd1) begin
      n_fail++; $display("FAIL t5_second: got pcnt %0d duty %0d required 1 1", period_counter, duty);
    end
    end_burst();
  endtask

  task automatic test_saturation;
    start_burst(16'd0, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    n_checks++;
    if ({period_tick, dir, duty, period_counter} !== {1'b1, 1'b0, 16'h0000, 16'd0}) begin
      n_fail++; $display("FAIL t6_k1: got %0h required %0h", {period_tick, dir, duty, period_counter}, {1'b1, 1'b0, 16'h0000, 16'd0});
    end
    @(negedge clk);
    n_checks++;
    if ({period_tick, dir, duty, period_counter} !== {1'b1, 1'b1, 16'hFFFF, 16'd1}) begin
      n_fail++; $display("FAIL t6_k2: got %0h required %0h", {period_tick, dir, duty, period_counter}, {1'b1, 1'b1, 16'hFFFF, 16'd1});
    end
    @(negedge clk);
    n_checks++;
    if ({period_tick, dir, duty, period_counter} !== {1'b1, 1'b0, 16'h0000, 16'd2}) begin
      n_fail++; $display("FAIL t6_k3: got %0h required %0h", {period_tick, dir, duty, period_counter}, {1'b1, 1'b0, 16'h0000, 16'd2});
    end
    for (int k = 4; k <= 65536; k++) begin
      @(negedge clk);
      n_checks++;
      if (period_tick !== 1'b1) begin
        n_fail++; $display("FAIL t6_tick k=%0d: got %0b required 1", k, period_tick);
      end
    end
    n_checks++;
    if (period_counter !== 16'hFFFF || duty !== 16'hFFFF) begin
      n_fail++; $display("FAIL t6_sat: got pcnt %0h duty %0h required ffff ffff", period_counter, duty);
    end
    @(negedge clk);
    n_checks++;
    if (period_counter !== 16'hFFFF || duty !== 16'h0000) begin
      n_fail++; $display("FAIL t6_sat_hold1: got pcnt %0h duty %0h required ffff 0", period_counter, duty);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (period_counter !== 16'hFFFF) begin
      n_fail++; $display("FAIL t6_sat_hold2: got %0h required ffff", period_counter);
    end
    end_burst();
    n_checks++;
    if (period_counter !== 16'd0) begin
      n_fail++; $display("FAIL t6_cleared: got %0h required 0", period_counter);
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_pwm_pattern();
    test_duty_extremes();
    test_ramp_clamp();
    test_abort_restart();
    test_drop_at_wrap();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
